multicycle_controller: RTL and testbench

// - Main control FSM for the multicycle RV32I core. It sequences the shared ALU and its

---
 rtl/riscv_pkg.sv | 69 ++++++
 rtl/multicycle_controller_alu_decoder.sv | 38 +++
 rtl/multicycle_controller.sv | 159 +++++++++++++++
 tb/tb_multicycle_controller.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control path.
// Holds the controller state enum, the opcodes the core understands, the ALU
// operation codes, and the datapath mux select encodings. It also provides the
// immediate-format helper that maps an opcode to its ImmSrc value.
package riscv_pkg;

  // Controller states; values 12-15 are unused and fall into the trap path
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALUOp: how the ALU decoder should interpret the instruction
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format is a pure function of the opcode; I-format covers loads,
  // ALU immediates and anything the core does not use an immediate for
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: turns the controller's ALUOp plus instruction fields into ALUControl.
// Ports:
//   alu_op      in  2  00 add, 01 sub, 10 decode from funct fields
//   funct3      in  3  instr[14:12]
//   op5         in  1  instr[5], separates R-type from I-type
//   funct7b5    in  1  instr[30]
//   alu_control out 3  operation code for the ALU
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  // Only an R-type with instr[30] set is a subtract; addi reuses instr[30] as
  // an immediate bit and must stay an add
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core.
// Sequences the shared ALU, its source muxes, memory, IR, PC and register file.
// It waits on MemReady during instruction fetch and data access. Unsupported
// opcodes park the FSM in a sticky TRAP state that only rst_n leaves.
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   Op, Funct3, Funct7b5          instruction fields from IR
//   Zero, MemReady                ALU zero flag, memory access completion
//   PCWrite, IRWrite, MemWrite, RegWrite   strobes (forced low during reset)
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB    datapath mux selects
//   ImmSrc                        immediate format, combinational from Op
//   ALUControl                    ALU operation
//   Trap                          illegal opcode seen
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Op,
  input  logic [2:0] Funct3,
  input  logic       Funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Trap
);

  state_t     state;
  state_t     next_state;
  logic       pc_write_raw;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic [1:0] alu_op;

  // State register; reset aborts any instruction and restarts at FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= next_state;
  end

  // Next-state logic; unused encodings and TRAP itself stay in TRAP
  always_comb begin
    next_state = TRAP;
    case (state)
      FETCH:    next_state = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECR;
          OP_I:         next_state = EXECI;
          OP_BEQ:       next_state = BEQ;
          OP_JAL:       next_state = JAL;
          default:      next_state = TRAP;
        endcase
      end
      MEMADR:   next_state = Op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  next_state = MemReady ? MEMWB : MEMREAD;
      MEMWB:    next_state = FETCH;
      MEMWRITE: next_state = MemReady ? FETCH : MEMWRITE;
      EXECR:    next_state = ALUWB;
      EXECI:    next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      BEQ:      next_state = FETCH;
      JAL:      next_state = ALUWB;
      default:  next_state = TRAP;
    endcase
  end

  // Output decode: Moore per state, except the FETCH strobes follow MemReady
  // and the branch PC update follows Zero
  always_comb begin
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RD2;
    alu_op        = ALUOP_ADD;
    Trap          = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB      = SRCB_FOUR;
        ResultSrc    = RES_ALURESULT;
        ir_write_raw = MemReady;
        pc_write_raw = MemReady;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc     = RES_DATA;
        reg_write_raw = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      EXECR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        alu_op  = ALUOP_FUNCT;
      end
      EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      ALUWB: reg_write_raw = 1'b1;
      BEQ: begin
        ALUSrcA      = SRCA_RD1;
        ALUSrcB      = SRCB_RD2;
        alu_op       = ALUOP_SUB;
        pc_write_raw = Zero;
      end
      JAL: begin
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_FOUR;
        pc_write_raw = 1'b1;
      end
      default: Trap = 1'b1;
    endcase
  end

  // Strobes are masked by rst_n so nothing fires while reset is held, even
  // though FETCH would otherwise follow MemReady
  assign PCWrite  = pc_write_raw & rst_n;
  assign MemWrite = mem_write_raw & rst_n;
  assign IRWrite  = ir_write_raw & rst_n;
  assign RegWrite = reg_write_raw & rst_n;

  assign ImmSrc = imm_src_of(Op);

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (Funct3),
    .op5         (Op[5]),
    .funct7b5    (Funct7b5),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller.
// Each instruction class is modelled as a list of micro-steps, each holding the
// datapath controls expected in that cycle. Steps that wait on memory repeat
// while MemReady is low. Outputs are sampled 1ns after the falling edge.
module tb_multicycle_controller;

  typedef enum int {K_LW, K_SW, K_R, K_I, K_BEQ, K_JAL} kind_t;

  // pcw_mode: 0 never, 1 always, 2 follows MemReady, 3 follows Zero
  typedef struct packed {
    logic [1:0] pcw_mode;
    logic       adr;
    logic       mw;
    logic       irw_ready;
    logic       rw;
    logic [1:0] res;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] alu;
    logic       waits;
    logic       trap;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] Op;
  logic [2:0] Funct3;
  logic       Funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Trap;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [16:0] obs;

  int compared   = 0;
  int mismatched = 0;
  step_t plan[$];

  multicycle_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Op         (Op),
    .Funct3     (Funct3),
    .Funct7b5   (Funct7b5),
    .Zero       (Zero),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .Trap       (Trap)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Trap};

  // Hard stop in case the sequence ever stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [6:0] op_of(kind_t k);
    case (k)
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_BEQ:   return 7'b1100011;
      default: return 7'b1101111;
    endcase
  endfunction

  function automatic logic [1:0] ref_imm(logic [6:0] op);
    if (op == 7'b0100011) return 2'b01;
    if (op == 7'b1100011) return 2'b10;
    if (op == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  // Arithmetic semantics of funct3: only R-type with instr[30] subtracts
  function automatic logic [2:0] ref_alu(logic [2:0] f3, logic is_r, logic f7b5);
    case (f3)
      3'b000:  return (is_r && f7b5) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic step_t mk(logic [1:0] pcw_mode, logic adr, logic mw, logic irw_ready,
                               logic rw, logic [1:0] res, logic [1:0] a, logic [1:0] b,
                               logic [2:0] alu, logic waits, logic trap);
    step_t s;
    s = '{pcw_mode, adr, mw, irw_ready, rw, res, a, b, alu, waits, trap};
    return s;
  endfunction

  function automatic step_t st_fetch();    return mk(2, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 1, 0); endfunction
  function automatic step_t st_decode();   return mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 0); endfunction
  function automatic step_t st_memadr();   return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0); endfunction
  function automatic step_t st_memread();  return mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0); endfunction
  function automatic step_t st_memwb();    return mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0, 0); endfunction
  function automatic step_t st_memwrite(); return mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0); endfunction
  function automatic step_t st_aluwb();    return mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0); endfunction
  function automatic step_t st_trap();     return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1); endfunction

  function automatic logic [16:0] exp_vec(step_t s, logic ready, logic zero, logic [6:0] op);
    logic pcw;
    case (s.pcw_mode)
      2'd0:    pcw = 1'b0;
      2'd1:    pcw = 1'b1;
      2'd2:    pcw = ready;
      default: pcw = zero;
    endcase
    return {pcw, s.adr, s.mw, s.irw_ready & ready, s.rw, s.res, s.src_a, s.src_b,
            s.alu, ref_imm(op), s.trap};
  endfunction

  // FETCH selects with every strobe held low
  function automatic logic [16:0] reset_vec(logic [6:0] op);
    return {5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, ref_imm(op), 1'b0};
  endfunction

  task automatic check_output(string tag, logic [16:0] observed, logic [16:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic build_plan(kind_t k, logic [2:0] f3, logic f7b5);
    plan.delete();
    plan.push_back(st_fetch());
    plan.push_back(st_decode());
    case (k)
      K_LW: begin plan.push_back(st_memadr()); plan.push_back(st_memread()); plan.push_back(st_memwb()); end
      K_SW: begin plan.push_back(st_memadr()); plan.push_back(st_memwrite()); end
      K_R: begin
        plan.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, ref_alu(f3, 1'b1, f7b5), 0, 0));
        plan.push_back(st_aluwb());
      end
      K_I: begin
        plan.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ref_alu(f3, 1'b0, f7b5), 0, 0));
        plan.push_back(st_aluwb());
      end
      K_BEQ: plan.push_back(mk(3, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0, 0));
      default: begin
        plan.push_back(mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 0));
        plan.push_back(st_aluwb());
      end
    endcase
  endtask

  // Walk the plan one cycle at a time; waiting steps repeat while MemReady is low
  task automatic apply_stimulus(string name, logic [6:0] op, logic [2:0] f3, logic f7b5,
                                logic zero, int fetch_stalls, int mem_stalls,
                                bit rand_ready, int limit, output int rw_seen);
    int idx = 0;
    int fs = fetch_stalls;
    int ms = mem_stalls;
    int held = 0;
    logic ready;
    rw_seen = 0;
    while (idx < plan.size() && idx < limit) begin
      @(negedge clk);
      Op = op; Funct3 = f3; Funct7b5 = f7b5; Zero = zero;
      if (plan[idx].waits) begin
        if (rand_ready)                ready = ($urandom_range(0, 3) != 0) || (held >= 6);
        else if (plan[idx].irw_ready) begin ready = (fs == 0); if (fs > 0) fs--; end
        else                           begin ready = (ms == 0); if (ms > 0) ms--; end
      end else begin
        ready = 1'($urandom_range(0, 1));
      end
      MemReady = ready;
      #1;
      check_output($sformatf("%s step%0d", name, idx), obs, exp_vec(plan[idx], ready, zero, op));
      if (RegWrite) rw_seen++;
      if (plan[idx].waits && !ready) held++;
      else begin idx++; held = 0; end
    end
  endtask

  task automatic run_instr(string name, kind_t k, logic [2:0] f3, logic f7b5, logic zero,
                           int fetch_stalls, int mem_stalls, bit rand_ready);
    int rw_seen;
    int rw_expected;
    build_plan(k, f3, f7b5);
    apply_stimulus(name, op_of(k), f3, f7b5, zero, fetch_stalls, mem_stalls, rand_ready, 100, rw_seen);
    rw_expected = (k == K_SW || k == K_BEQ) ? 0 : 1;
    check_output({name, " regwrite_count"}, 17'(rw_seen), 17'(rw_expected));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    MemReady = 1'b1;
    #1;
    check_output("reset_assert", obs, reset_vec(Op));
    @(negedge clk);
    #1;
    check_output("reset_hold", obs, reset_vec(Op));
    MemReady = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic run_trap(string name, logic [6:0] op);
    int rw_seen;
    plan.delete();
    plan.push_back(st_fetch());
    plan.push_back(st_decode());
    for (int i = 0; i < 10; i++) plan.push_back(st_trap());
    apply_stimulus(name, op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 0, 0, 1'b0, 100, rw_seen);
    do_reset();
    check_output({name, " trap_cleared"}, {16'd0, Trap}, 17'd0);
  endtask

  function automatic bit is_legal(logic [6:0] op);
    return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
           op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111;
  endfunction

  initial begin
    int rw_seen;
    logic [6:0] bad_op;
    rst_n = 1'b0;
    Op = 7'b0110011; Funct3 = 3'b000; Funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b0;
    do_reset();

    // add x3,x1,x2
    run_instr("add", K_R, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    // lw with two wait cycles on the data read
    run_instr("lw_stall", K_LW, 3'b010, 1'b0, 1'b0, 0, 2, 1'b0);
    run_instr("sw_stall", K_SW, 3'b010, 1'b0, 1'b0, 1, 1, 1'b0);
    run_instr("beq_taken", K_BEQ, 3'b000, 1'b0, 1'b1, 0, 0, 1'b0);
    run_instr("beq_not_taken", K_BEQ, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr("jal", K_JAL, 3'b000, 1'b0, 1'b0, 2, 0, 1'b0);
    run_instr("sub", K_R, 3'b000, 1'b1, 1'b0, 0, 0, 1'b0);
    run_instr("addi_f7", K_I, 3'b000, 1'b1, 1'b0, 0, 0, 1'b0);
    run_instr("or", K_R, 3'b110, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr("and", K_R, 3'b111, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr("slt", K_R, 3'b010, 1'b0, 1'b0, 0, 0, 1'b0);

    // Illegal opcode, then reset out of the trap
    run_trap("trap_ff", 7'b1111111);

    // Reset dropped mid-store while memory is still busy
    build_plan(K_SW, 3'b010, 1'b0);
    apply_stimulus("sw_abort", 7'b0100011, 3'b010, 1'b0, 1'b0, 0, 0, 1'b0, 3, rw_seen);
    @(negedge clk);
    MemReady = 1'b0;
    #1;
    check_output("sw_abort memwrite", obs, exp_vec(st_memwrite(), 1'b0, 1'b0, Op));
    #2;
    rst_n = 1'b0;
    #1;
    check_output("sw_abort async", obs, reset_vec(Op));
    MemReady = 1'b1;
    #1;
    check_output("sw_abort ready_in_reset", obs, reset_vec(Op));
    @(negedge clk);
    MemReady = 1'b0;
    rst_n = 1'b1;
    #1;
    check_output("sw_abort fetch_wait", obs, exp_vec(st_fetch(), 1'b0, 1'b0, Op));
    @(negedge clk);
    MemReady = 1'b1;
    #1;
    check_output("sw_abort fetch_go", obs, exp_vec(st_fetch(), 1'b1, 1'b0, Op));
    do_reset();

    // Random instruction stream with random memory latency
    for (int n = 0; n < 40; n++) begin
      kind_t k;
      k = kind_t'($urandom_range(0, 5));
      run_instr($sformatf("rand%0d_%s", n, k.name()), k, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 1'b1);
    end

    // A few random illegal opcodes
    for (int n = 0; n < 3; n++) begin
      bad_op = 7'($urandom_range(0, 127));
      while (is_legal(bad_op)) bad_op = 7'($urandom_range(0, 127));
      run_trap($sformatf("trap_rand%0d", n), bad_op);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
